// File: rtl/lc3_fetch_ctrl.sv
// LC3 fetch-stage sequencer: PC register, stage enables and data-memory stall phases.
// Optional build macro LC3_FETCH_EXT_STALL_EN adds an ext_stall freeze input.
module lc3_fetch_ctrl #(
    parameter logic [15:0] START_PC     = 16'h3000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    input  logic        mem_req,
    input  logic        mem_indirect,
    input  logic        mem_write,
`ifdef LC3_FETCH_EXT_STALL_EN
    input  logic        ext_stall,
`endif
    output logic [15:0] npc,
    output logic [15:0] pc,
    output logic        imem_rd,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic [1:0]  mem_state
);

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        FLUSH,
        MEM_IND,
        MEM_DATA
    } state_t;

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t      state, state_nx;
    logic [15:0] pc_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        wr_q, wr_nx;
    logic        frz;

`ifdef LC3_FETCH_EXT_STALL_EN
    assign frz = ext_stall && (state != BOOT);
`else
    assign frz = 1'b0;
`endif

    assign npc = pc + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= START_PC;
            cnt   <= 3'd0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cnt   <= cnt_nx;
            wr_q  <= wr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        wr_nx    = wr_q;
        if (!frz) begin
            case (state)
                BOOT: state_nx = RUN;
                RUN: begin
                    if (br_taken) begin
                        pc_nx    = taddr;
                        cnt_nx   = FC;
                        state_nx = FLUSH;
                    end else if (mem_req) begin
                        wr_nx    = mem_write;
                        state_nx = mem_indirect ? MEM_IND : MEM_DATA;
                    end else begin
                        pc_nx = npc;
                    end
                end
                FLUSH: begin
                    pc_nx  = npc;
                    cnt_nx = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        cnt_nx   = 3'd0;
                        state_nx = RUN;
                    end
                end
                MEM_IND:  state_nx = MEM_DATA;
                MEM_DATA: state_nx = RUN;
                default:  state_nx = BOOT;
            endcase
        end
    end

    always_comb begin
        imem_rd          = 1'b0;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        mem_state        = 2'd3;
        case (state)
            RUN: begin
                imem_rd          = 1'b1;
                enable_fetch     = 1'b1;
                enable_decode    = 1'b1;
                enable_execute   = 1'b1;
                enable_writeback = 1'b1;
            end
            FLUSH: begin
                imem_rd          = 1'b1;
                enable_fetch     = 1'b1;
                enable_execute   = 1'b1;
                enable_writeback = 1'b1;
            end
            MEM_IND: mem_state = 2'd1;
            MEM_DATA: begin
                enable_writeback = ~wr_q;
                mem_state        = wr_q ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
        // A frozen pipeline keeps reporting which memory phase it is parked in.
        if (frz) begin
            imem_rd          = 1'b0;
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Testbench for lc3_fetch_ctrl: directed vector table, ext_stall sequence,
// and randomized traffic against a phase-queue reference model.
module tb_lc3_fetch_ctrl;

    localparam logic [15:0] START = 16'h3000;
    localparam int          FC    = 2;

    logic        clock = 1'b0;
    logic        reset, br_taken, mem_req, mem_indirect, mem_write, ext_stall;
    logic [15:0] taddr;
    logic [15:0] npc, pc;
    logic        imem_rd, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic [1:0]  mem_state;

    always #5 clock = ~clock;

    lc3_fetch_ctrl #(.START_PC(START), .FLUSH_CYCLES(FC)) dut (
        .clock(clock),
        .reset(reset),
        .br_taken(br_taken),
        .taddr(taddr),
        .mem_req(mem_req),
        .mem_indirect(mem_indirect),
        .mem_write(mem_write),
`ifdef LC3_FETCH_EXT_STALL_EN
        .ext_stall(ext_stall),
`endif
        .npc(npc),
        .pc(pc),
        .imem_rd(imem_rd),
        .enable_fetch(enable_fetch),
        .enable_decode(enable_decode),
        .enable_execute(enable_execute),
        .enable_writeback(enable_writeback),
        .mem_state(mem_state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // en bundle order: {imem_rd, fetch, decode, execute, writeback}
    localparam logic [4:0] E_OFF = 5'b00000;
    localparam logic [4:0] E_RUN = 5'b11111;
    localparam logic [4:0] E_FL  = 5'b11011;
    localparam logic [4:0] E_RD  = 5'b00001;

    task automatic check(input string nm, input logic [15:0] epc,
                         input logic [4:0] een, input logic [1:0] ems);
        logic [38:0] act, exp;
        act = {pc, npc, imem_rd, enable_fetch, enable_decode,
               enable_execute, enable_writeback, mem_state};
        exp = {epc, epc + 16'd1, een, ems};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h npc=%h en=%b ms=%0d, want pc=%h npc=%h en=%b ms=%0d",
                     nm, act[38:23], act[22:7], act[6:2], act[1:0],
                     exp[38:23], exp[22:7], exp[6:2], exp[1:0]);
        end
    endtask

    typedef struct {
        logic        rst, br;
        logic [15:0] ta;
        logic        req, ind, wr, chk;
        logic [15:0] pc;
        logic [4:0]  en;
        logic [1:0]  ms;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(logic rst, logic br, logic [15:0] ta, logic req,
                               logic ind, logic wr, logic chk, logic [15:0] p,
                               logic [4:0] en, logic [1:0] ms);
        vec_t r;
        r.rst = rst; r.br = br; r.ta = ta; r.req = req; r.ind = ind;
        r.wr = wr; r.chk = chk; r.pc = p; r.en = en; r.ms = ms;
        return r;
    endfunction

    // Reference model: boot flag, flush countdown and a queue of pending
    // memory phases (the mem_state value each stall cycle shows).
    bit          m_boot;
    logic [15:0] m_pc;
    int          m_flush;
    logic [1:0]  m_q[$];

    task automatic model_exp(output logic [15:0] p, output logic [4:0] en,
                             output logic [1:0] ms);
        p  = m_pc;
        en = E_OFF;
        ms = 2'd3;
        if (m_boot) en = E_OFF;
        else if (m_q.size() > 0) begin
            ms = m_q[0];
            en = (m_q[0] == 2'd0) ? E_RD : E_OFF;
        end else if (m_flush > 0) en = E_FL;
        else en = E_RUN;
        if (!m_boot && ext_stall) en = E_OFF;
    endtask

    task automatic model_step();
        if (reset) begin
            m_boot = 1; m_pc = START; m_flush = 0; m_q.delete();
        end else if (m_boot) m_boot = 0;
        else if (ext_stall) ;
        else if (m_q.size() > 0) void'(m_q.pop_front());
        else if (m_flush > 0) begin
            m_pc = m_pc + 16'd1; m_flush--;
        end else if (br_taken) begin
            m_pc = taddr; m_flush = FC;
        end else if (mem_req) begin
            if (mem_indirect) m_q.push_back(2'd1);
            m_q.push_back(mem_write ? 2'd2 : 2'd0);
        end else m_pc = m_pc + 16'd1;
    endtask

    task automatic drive(logic rst, logic br, logic [15:0] ta, logic req,
                         logic ind, logic wr);
        reset = rst; br_taken = br; taddr = ta;
        mem_req = req; mem_indirect = ind; mem_write = wr;
    endtask

    initial begin
        logic [15:0] ep;
        logic [4:0]  ee;
        logic [1:0]  em;
        ext_stall = 1'b0;
        tbl[0]  = v(1,0,0,0,0,0, 0, 16'h0000, E_OFF, 3);
        tbl[1]  = v(1,0,0,0,0,0, 1, 16'h3000, E_OFF, 3);
        tbl[2]  = v(1,0,0,0,0,0, 1, 16'h3000, E_OFF, 3);
        tbl[3]  = v(0,0,0,0,0,0, 1, 16'h3000, E_OFF, 3);
        tbl[4]  = v(0,0,0,0,0,0, 1, 16'h3000, E_RUN, 3);
        tbl[5]  = v(0,0,0,0,0,0, 1, 16'h3001, E_RUN, 3);
        tbl[6]  = v(0,0,0,0,0,0, 1, 16'h3002, E_RUN, 3);
        tbl[7]  = v(0,0,0,0,0,0, 1, 16'h3003, E_RUN, 3);
        tbl[8]  = v(0,0,0,0,0,0, 1, 16'h3004, E_RUN, 3);
        tbl[9]  = v(0,1,16'h4000,0,0,0, 1, 16'h3005, E_RUN, 3);
        tbl[10] = v(0,0,0,0,0,0, 1, 16'h4000, E_FL, 3);
        tbl[11] = v(0,1,16'h7777,1,0,0, 1, 16'h4001, E_FL, 3);
        tbl[12] = v(0,1,16'h300E,0,0,0, 1, 16'h4002, E_RUN, 3);
        tbl[13] = v(0,0,0,0,0,0, 1, 16'h300E, E_FL, 3);
        tbl[14] = v(0,0,0,0,0,0, 1, 16'h300F, E_FL, 3);
        tbl[15] = v(0,0,0,1,1,0, 1, 16'h3010, E_RUN, 3);
        tbl[16] = v(0,0,0,0,0,1, 1, 16'h3010, E_OFF, 1);
        tbl[17] = v(0,0,0,0,0,1, 1, 16'h3010, E_RD, 0);
        tbl[18] = v(0,0,0,0,0,0, 1, 16'h3010, E_RUN, 3);
        tbl[19] = v(0,1,16'h5000,1,0,1, 1, 16'h3011, E_RUN, 3);
        tbl[20] = v(0,0,0,0,0,0, 1, 16'h5000, E_FL, 3);
        tbl[21] = v(0,0,0,0,0,0, 1, 16'h5001, E_FL, 3);
        tbl[22] = v(0,0,0,1,0,1, 1, 16'h5002, E_RUN, 3);
        tbl[23] = v(0,0,0,0,0,0, 1, 16'h5002, E_OFF, 2);
        tbl[24] = v(0,1,16'hFFFD,0,0,0, 1, 16'h5002, E_RUN, 3);
        tbl[25] = v(0,0,0,0,0,0, 1, 16'hFFFD, E_FL, 3);
        tbl[26] = v(0,0,0,0,0,0, 1, 16'hFFFE, E_FL, 3);
        tbl[27] = v(0,0,0,0,0,0, 1, 16'hFFFF, E_RUN, 3);
        tbl[28] = v(0,0,0,1,1,0, 1, 16'h0000, E_RUN, 3);
        tbl[29] = v(1,0,0,0,0,0, 1, 16'h0000, E_OFF, 1);
        tbl[30] = v(0,0,0,0,0,0, 1, 16'h3000, E_OFF, 3);
        tbl[31] = v(0,0,0,0,0,0, 1, 16'h3000, E_RUN, 3);

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst, tbl[i].br, tbl[i].ta, tbl[i].req, tbl[i].ind, tbl[i].wr);
            @(negedge clock);
            if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].en, tbl[i].ms);
            @(posedge clock);
            #1;
        end

`ifdef LC3_FETCH_EXT_STALL_EN
        drive(1,0,0,0,0,0);
        @(posedge clock); #1;
        drive(0,0,0,0,0,0);
        @(posedge clock); #1;
        drive(0,1,16'h4000,0,0,0);
        @(posedge clock); #1;
        drive(0,0,0,0,0,0);
        @(negedge clock); check("xs_fl0", 16'h4000, E_FL, 3);
        @(posedge clock); #1;
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); check($sformatf("xs_hold%0d", i), 16'h4001, E_OFF, 3);
            @(posedge clock); #1;
        end
        ext_stall = 1'b0;
        @(negedge clock); check("xs_fl1", 16'h4001, E_FL, 3);
        @(posedge clock); #1;
        @(negedge clock); check("xs_run", 16'h4002, E_RUN, 3);
        @(posedge clock); #1;
`endif

        drive(1,0,0,0,0,0);
        ext_stall = 1'b0;
        @(posedge clock);
        model_step();
        #1;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 60) == 0, ($urandom % 8) == 0, 16'($urandom),
                  ($urandom % 4) == 0, 1'($urandom), 1'($urandom));
`ifdef LC3_FETCH_EXT_STALL_EN
            ext_stall = ($urandom % 6) == 0;
`endif
            @(negedge clock);
            model_exp(ep, ee, em);
            check($sformatf("rand%0d", c), ep, ee, em);
            @(posedge clock);
            model_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
